// File: rtl/cnn_pkg.sv
// cnn_pkg: shared state encoding and default widths for the CNN address generators
package cnn_pkg;
    localparam int DIM_W_DEF  = 8;
    localparam int ADDR_W_DEF = 16;
    localparam int CNT_W_DEF  = 16;
    typedef enum logic {IDLE, RUN} state_e;
endpackage

// File: rtl/wrap_counter.sv
// wrap_counter: stepping position counter that returns to zero once value+step passes limit
module wrap_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] step_i,
    input  logic [W-1:0] limit_i,
    output logic [W-1:0] nxt_o,
    output logic         wrap_o
);
    logic [W-1:0] value_q, value_d;
    // One extra bit so value+step never wraps near the top of the range
    assign wrap_o = ({1'b0, value_q} + {1'b0, step_i}) > {1'b0, limit_i};
    // Clear beats enable; on enable either step forward or fold back to zero
    always_comb value_d = clr_i ? '0 : (en_i ? (wrap_o ? '0 : value_q + step_i) : value_q);
    // Position register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) value_q <= '0;
        else value_q <= value_d;
    assign nxt_o = value_d;
endmodule

// File: rtl/conv_window_counter.sv
// conv_window_counter: walks a square feature map in convolution order emitting kernel-tap addresses
module conv_window_counter
    import cnn_pkg::*;
#(
    parameter int DIM_W  = DIM_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DIM_W-1:0]  size,
    input  logic [DIM_W-1:0]  ksize,
    input  logic [DIM_W-1:0]  stride,
    output logic [ADDR_W-1:0] addr,
    output logic              valid,
    input  logic              ready,
    output logic              last_k,
    output logic              last,
    output logic              done,
    output logic              err,
    output logic              busy,
    output logic [CNT_W-1:0]  count
);
    localparam int DW2 = 2 * DIM_W;
    state_e state_q, state_d;
    logic [DIM_W-1:0] size_q, ksize_q, stride_q, size_d, ksize_d, stride_d, kmax_d;
    logic [DIM_W-1:0] kc_n, kr_n, col_n, row_n;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DW2-1:0] lin;
    logic last_k_q, last_k_d, last_q, last_d, done_q, done_d, err_q, err_d;
    logic cfg_ok, accept, hs, fin, clr, run_n, row_end_n, map_end_n;
    logic wrap_kc, wrap_kr, wrap_col, wrap_row;
    // Start decode, handshake and next state; abort overrides everything else
    always_comb begin
        cfg_ok  = ksize != '0 && stride != '0 && ksize <= size;
        accept  = state_q == IDLE && start && !abort && cfg_ok;
        err_d   = state_q == IDLE && start && !abort && !cfg_ok;
        hs      = state_q == RUN && ready && !abort;
        fin     = hs && last_q;
        done_d  = fin;
        clr     = accept || abort;
        state_d = abort ? IDLE : (accept ? RUN : (fin ? IDLE : state_q));
        run_n   = state_d == RUN;
        count_d = accept ? '0 : ((hs && count_q != '1) ? count_q + CNT_W'(1) : count_q);
    end
    // Configuration as it will be seen by the next tap
    always_comb begin
        size_d   = accept ? size : size_q;
        ksize_d  = accept ? ksize : ksize_q;
        stride_d = accept ? stride : stride_q;
        kmax_d   = ksize_d - DIM_W'(1);
    end
    wrap_counter #(.W(DIM_W)) u_kc (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .en_i(hs),
        .step_i(DIM_W'(1)), .limit_i(ksize_q - DIM_W'(1)), .nxt_o(kc_n), .wrap_o(wrap_kc)
    );
    wrap_counter #(.W(DIM_W)) u_kr (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .en_i(hs && wrap_kc),
        .step_i(DIM_W'(1)), .limit_i(ksize_q - DIM_W'(1)), .nxt_o(kr_n), .wrap_o(wrap_kr)
    );
    wrap_counter #(.W(DIM_W)) u_col (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .en_i(hs && wrap_kc && wrap_kr),
        .step_i(stride_q), .limit_i(size_q - ksize_q), .nxt_o(col_n), .wrap_o(wrap_col)
    );
    wrap_counter #(.W(DIM_W)) u_row (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .en_i(hs && wrap_kc && wrap_kr && wrap_col),
        .step_i(stride_q), .limit_i(size_q - ksize_q), .nxt_o(row_n), .wrap_o(wrap_row)
    );
    // Address and end-of-window/pass flags for the tap presented next cycle
    always_comb begin
        lin       = (DW2'(row_n) + DW2'(kr_n)) * DW2'(size_d) + DW2'(col_n) + DW2'(kc_n);
        addr_d    = run_n ? ADDR_W'(lin) : '0;
        row_end_n = ({1'b0, col_n} + {1'b0, stride_d} + {1'b0, ksize_d}) > {1'b0, size_d};
        map_end_n = ({1'b0, row_n} + {1'b0, stride_d} + {1'b0, ksize_d}) > {1'b0, size_d};
        last_k_d  = run_n && kc_n == kmax_d && kr_n == kmax_d;
        last_d    = last_k_d && row_end_n && map_end_n;
    end
    // FSM state, latched configuration and all registered outputs
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q  <= IDLE;
            size_q   <= '0;
            ksize_q  <= '0;
            stride_q <= '0;
            addr_q   <= '0;
            last_k_q <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            size_q   <= size_d;
            ksize_q  <= ksize_d;
            stride_q <= stride_d;
            addr_q   <= addr_d;
            last_k_q <= last_k_d;
            last_q   <= last_d;
            done_q   <= done_d;
            err_q    <= err_d;
            count_q  <= count_d;
        end
    assign valid  = state_q == RUN;
    assign busy   = state_q == RUN;
    assign addr   = addr_q;
    assign last_k = last_k_q;
    assign last   = last_q;
    assign done   = done_q;
    assign err    = err_q;
    assign count  = count_q;
endmodule

// File: tb/tb_conv_window_counter.sv
// tb_conv_window_counter: random and directed passes checked against a tap-list reference model
module tb_conv_window_counter;
    logic clk, rst_n, start, abort, ready;
    logic [7:0] size, ksize, stride;
    logic [15:0] addr, count;
    logic valid, last_k, last, done, err, busy;

    conv_window_counter dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .size(size), .ksize(ksize), .stride(stride),
        .addr(addr), .valid(valid), .ready(ready), .last_k(last_k), .last(last),
        .done(done), .err(err), .busy(busy), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {logic [15:0] a; logic lk; logic l;} tap_t;
    tap_t mq[$];
    int seen[$];
    int t1[$];
    logic m_run, m_done, m_err;
    int m_count;
    int n_cmp = 0, n_bad = 0;
    int mode = 0, phase = 0;
    logic [3:0] pat = 4'b1001;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Enumerate every tap of a pass directly from window geometry
    task automatic build(input int s, input int k, input int st);
        int nw = (s - k) / st + 1;
        tap_t t;
        mq.delete();
        for (int r = 0; r < nw; r++)
            for (int c = 0; c < nw; c++)
                for (int kr = 0; kr < k; kr++)
                    for (int kc = 0; kc < k; kc++) begin
                        t.a  = 16'(((r * st + kr) * s + c * st + kc) & 16'hFFFF);
                        t.lk = (kr == k - 1) && (kc == k - 1);
                        t.l  = t.lk && (r == nw - 1) && (c == nw - 1);
                        mq.push_back(t);
                    end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0; m_done = 0; m_err = 0; m_count = 0; mq.delete();
        end else begin
            m_done = 0; m_err = 0;
            if (abort) begin
                m_run = 0; mq.delete();
            end else if (!m_run && start) begin
                if (ksize == 0 || stride == 0 || ksize > size) m_err = 1;
                else begin
                    build(int'(size), int'(ksize), int'(stride));
                    m_count = 0; m_run = 1;
                end
            end else if (m_run && ready) begin
                void'(mq.pop_front());
                if (m_count < 65535) m_count++;
                if (mq.size() == 0) begin m_run = 0; m_done = 1; end
            end
        end
    end

    always @(posedge clk)
        if (rst_n && valid && ready && !abort) seen.push_back(int'(addr));

    always @(negedge clk) begin
        chk("valid", valid, m_run);
        chk("busy", busy, m_run);
        chk("addr", addr, (m_run && mq.size() > 0) ? mq[0].a : 0);
        chk("last_k", last_k, (m_run && mq.size() > 0) ? mq[0].lk : 0);
        chk("last", last, (m_run && mq.size() > 0) ? mq[0].l : 0);
        chk("done", done, m_done);
        chk("err", err, m_err);
        chk("count", count, m_count);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        phase++;
        if (mode == 0) ready = 1'b1;
        else if (mode == 1) ready = pat[phase % 4];
        else begin
            ready = 1'($urandom_range(0, 1));
            abort = ($urandom_range(0, 199) == 0);
        end
    endtask

    task automatic start_pass(input int s, input int k, input int st);
        size = 8'(s); ksize = 8'(k); stride = 8'(st); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (valid && n < 4000) begin tick(); n++; end
        chk("pass_timeout", valid, 0);
    endtask

    initial begin
        int f9[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        int c0, n, bad;
        rst_n = 0; start = 0; abort = 0; ready = 1; size = 0; ksize = 0; stride = 0;
        repeat (3) tick();
        rst_n = 1;
        tick();
        seen.delete();
        start_pass(4, 3, 1);
        chk("t1_first_addr", addr, 0);
        wait_idle();
        chk("t1_done", done, 1);
        chk("t1_taps", seen.size(), 36);
        for (int i = 0; i < 9; i++) chk("t1_win0", seen.size() > i ? seen[i] : -1, f9[i]);
        chk("t1_final_addr", seen.size() > 35 ? seen[35] : -1, 15);
        chk("t1_count", count, 36);
        t1 = seen;
        tick();
        chk("t1_done_pulse", done, 0);
        seen.delete();
        start_pass(5, 3, 2);
        wait_idle();
        chk("t2_done", done, 1);
        chk("t2_taps", seen.size(), 36);
        chk("t2_win1", seen.size() > 9 ? seen[9] : -1, 2);
        chk("t2_win2", seen.size() > 18 ? seen[18] : -1, 10);
        chk("t2_win3", seen.size() > 27 ? seen[27] : -1, 12);
        chk("t2_final_addr", seen.size() > 35 ? seen[35] : -1, 24);
        chk("t2_count", count, 36);
        seen.delete();
        start_pass(3, 1, 1);
        wait_idle();
        chk("t3_taps", seen.size(), 9);
        for (int i = 0; i < 9; i++) chk("t3_addr", seen.size() > i ? seen[i] : -1, i);
        chk("t3_count", count, 9);
        seen.delete();
        mode = 1;
        start_pass(4, 3, 1);
        wait_idle();
        mode = 0;
        chk("t4_taps", seen.size(), 36);
        bad = 0;
        for (int i = 0; i < 36; i++) if (seen.size() <= i || t1.size() <= i || seen[i] != t1[i]) bad++;
        chk("t4_sequence", bad, 0);
        chk("t4_count", count, 36);
        tick();
        c0 = int'(count);
        start_pass(4, 5, 1);
        chk("e1_err", err, 1);
        chk("e1_valid", valid, 0);
        chk("e1_count", count, c0);
        tick();
        chk("e1_err_pulse", err, 0);
        start_pass(4, 3, 0);
        chk("e2_err", err, 1);
        chk("e2_valid", valid, 0);
        chk("e2_count", count, c0);
        seen.delete();
        start_pass(6, 3, 1);
        n = 0;
        while (seen.size() < 10 && n < 100) begin tick(); n++; end
        abort = 1;
        tick();
        abort = 0;
        chk("ab_valid", valid, 0);
        chk("ab_done", done, 0);
        chk("ab_count", count, 10);
        start_pass(4, 3, 1);
        chk("ab_restart_valid", valid, 1);
        chk("ab_restart_addr", addr, 0);
        wait_idle();
        start_pass(5, 3, 2);
        repeat (5) tick();
        #2 rst_n = 0;
        #1;
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", addr, 0);
        chk("rst_last_k", last_k, 0);
        chk("rst_count", count, 0);
        tick();
        rst_n = 1;
        tick();
        mode = 2;
        for (int it = 0; it < 12; it++) begin
            int s = $urandom_range(1, 12);
            start_pass(s, $urandom_range(0, s + 1), $urandom_range(0, 4));
            wait_idle();
            tick();
        end
        mode = 0;
        abort = 0;
        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
